// File: rtl/pudc_pkg.sv
// ---------------------------------------------------------------------------
// pudc_pkg -- shared definitions for the param_updown_counter family.
//
// Contents:
//   DIR_UP / DIR_DOWN : encodings of the dir input.
//   clamp()           : saturating min used to bound load values to MAX_VAL.
//   params_legal()    : parameter legality predicate, evaluated at elaboration
//                       by the top (WIDTH>=2, MAX_VAL fits WIDTH, RST_VAL<=MAX_VAL).
// ---------------------------------------------------------------------------
package pudc_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // 64-bit arithmetic so the helper serves any counter width up to 64.
    function automatic longint unsigned clamp(input longint unsigned value,
                                              input longint unsigned max_val);
        return (value > max_val) ? max_val : value;
    endfunction

    function automatic bit params_legal(input int unsigned      width,
                                        input longint unsigned max_val,
                                        input longint unsigned rst_val);
        longint unsigned top;
        top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (width >= 2) && (width <= 64) && (max_val <= top) && (rst_val <= max_val);
    endfunction

endpackage

// File: rtl/pudc_next_val.sv
// ---------------------------------------------------------------------------
// pudc_next_val -- combinational next-count and boundary detection.
//
// Optional feature macro: PUDC_SATURATE_EN
//   undefined : a step at the boundary wraps (MAX_VAL->0 up, 0->MAX_VAL down).
//   defined   : a step at the boundary is blocked and the count holds.
//   In both builds boundary_hit marks an enabled step taken at the boundary.
//
// Ports:
//   count        in  WIDTH  current registered count
//   dir          in  1      1 = up, 0 = down
//   en           in  1      count enable
//   ld           in  1      synchronous load request
//   ld_value     in  WIDTH  load value (clamped to MAX_VAL)
//   clr          in  1      synchronous clear to RST_VAL
//   next_count   out WIDTH  value for the count register
//   boundary_hit out 1      enabled step attempted at the boundary
// Priority: clr > ld > en > hold.
// ---------------------------------------------------------------------------
module pudc_next_val
    import pudc_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RST_VAL = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_value,
    input  logic             clr,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary_hit
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    logic             at_edge;
    logic [WIDTH-1:0] ld_clamped;

    // The boundary compare is made before the step, so the arithmetic never
    // leaves the 0..MAX_VAL range even for non-power-of-two moduli.
    assign at_edge    = (dir == DIR_UP) ? (count == MAX_W) : (count == '0);
    assign ld_clamped = WIDTH'(clamp(64'(ld_value), MAX_VAL));

    always_comb begin
        next_count   = count;
        boundary_hit = 1'b0;
        if (clr) begin
            next_count = RST_W;
        end else if (ld) begin
            next_count = ld_clamped;
        end else if (en) begin
            boundary_hit = at_edge;
            if (at_edge) begin
`ifdef PUDC_SATURATE_EN
                next_count = count;
`else
                next_count = (dir == DIR_UP) ? '0 : MAX_W;
`endif
            end else begin
                next_count = (dir == DIR_UP) ? (count + 1'b1) : (count - 1'b1);
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter -- parametrised up/down counter, range 0..MAX_VAL.
//
// Optional feature macro: PUDC_SATURATE_EN (saturate instead of wrap; the
// wrap output then pulses for each enabled step blocked at a boundary).
//
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous reset, active-low
//   clr       in  1      synchronous clear to RST_VAL (highest sync priority)
//   ld        in  1      synchronous load of ld_value
//   ld_value  in  WIDTH  load value, clamped to MAX_VAL
//   en        in  1      count enable
//   dir       in  1      1 = up, 0 = down
//   count     out WIDTH  registered count
//   tc        out 1      combinational terminal count for cascading
//   wrap      out 1      registered one-cycle pulse after a wrap (or blocked) step
// ---------------------------------------------------------------------------
module param_updown_counter
    import pudc_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_value,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    if (!params_legal(WIDTH, MAX_VAL, RST_VAL)) begin : g_param_check
        $error("param_updown_counter: illegal WIDTH/MAX_VAL/RST_VAL combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] next_count;
    logic             boundary_hit;

    pudc_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .RST_VAL (RST_VAL)
    ) u_next_val (
        .count        (count_q),
        .dir          (dir),
        .en           (en),
        .ld           (ld),
        .ld_value     (ld_value),
        .clr          (clr),
        .next_count   (next_count),
        .boundary_hit (boundary_hit)
    );

    always_comb begin
        count_d = next_count;
        wrap_d  = boundary_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_W;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // tc tracks the live dir so a cascade sees the boundary it is heading to.
    assign tc    = ((dir == DIR_UP)   && (count_q == MAX_W)) ||
                   ((dir == DIR_DOWN) && (count_q == '0));
    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         ld;
    logic [W-1:0] ld_value;
    logic         en;
    logic         dir;

    logic [W-1:0] count_s, count_f;
    logic         tc_s, tc_f, wrap_s, wrap_f;

    int checks;
    int errors;

    // Small modulus (0..9) instance: the main subject of the vector table.
    param_updown_counter #(.WIDTH(W), .MAX_VAL(9), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_value(ld_value),
        .en(en), .dir(dir), .count(count_s), .tc(tc_s), .wrap(wrap_s)
    );

    // Full-range instance sharing the same stimulus.
    param_updown_counter #(.WIDTH(W)) dut_full (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_value(ld_value),
        .en(en), .dir(dir), .count(count_f), .tc(tc_f), .wrap(wrap_f)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, actual, expected);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [W-1:0] v,
                         input logic e, input logic d);
        clr = c; ld = l; ld_value = v; en = e; dir = d;
    endtask

    typedef struct {
        logic         clr;
        logic         ld;
        logic [W-1:0] ldv;
        logic         en;
        logic         dir;
        logic [W-1:0] exp_count;
        logic         exp_tc;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic l, input logic [W-1:0] v,
                                input logic e, input logic d, input logic [W-1:0] ec,
                                input logic et, input logic ew);
        vec_t r;
        r.clr = c; r.ld = l; r.ldv = v; r.en = e; r.dir = d;
        r.exp_count = ec; r.exp_tc = et; r.exp_wrap = ew;
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Expected count/tc/wrap of the MAX_VAL=9 instance after each edge.
        //            clr ld ldv    en dir   count tc wrap
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd1, 0, 0)); // plain up step
        vecs.push_back(mk(0, 1, 8'd8,   1, 1,  8'd8, 0, 0)); // ld beats en
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd9, 1, 0)); // reach top, tc
`ifdef PUDC_SATURATE_EN
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd9, 1, 1)); // blocked at top
        vecs.push_back(mk(0, 0, 8'd0,   0, 1,  8'd9, 1, 0)); // pulse ends
        vecs.push_back(mk(0, 0, 8'd0,   0, 0,  8'd9, 0, 0)); // hold, dir down
`else
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd0, 0, 1)); // up wrap
        vecs.push_back(mk(0, 0, 8'd0,   0, 1,  8'd0, 0, 0)); // pulse ends
        vecs.push_back(mk(0, 0, 8'd0,   0, 0,  8'd0, 1, 0)); // tc at 0 going down
`endif
        vecs.push_back(mk(0, 1, 8'd0,   0, 0,  8'd0, 1, 0)); // load 0
`ifdef PUDC_SATURATE_EN
        vecs.push_back(mk(0, 0, 8'd0,   1, 0,  8'd0, 1, 1)); // blocked at 0
        vecs.push_back(mk(0, 0, 8'd0,   1, 0,  8'd0, 1, 1)); // blocked again
`else
        vecs.push_back(mk(0, 0, 8'd0,   1, 0,  8'd9, 0, 1)); // down wrap
        vecs.push_back(mk(0, 0, 8'd0,   1, 0,  8'd8, 0, 0)); // plain down step
`endif
        vecs.push_back(mk(1, 1, 8'd3,   1, 1,  8'd0, 0, 0)); // clr beats ld/en
        vecs.push_back(mk(0, 1, 8'd3,   1, 1,  8'd3, 0, 0)); // ld, no step
        vecs.push_back(mk(0, 1, 8'hC8,  0, 1,  8'd9, 1, 0)); // load clamp
`ifdef PUDC_SATURATE_EN
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd9, 1, 1));
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd9, 1, 1));
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd9, 1, 1));
`else
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd1, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 1,  8'd2, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 8'd0,   1, 0,  8'd0, 1, 0)); // clr kills step
        vecs.push_back(mk(0, 1, 8'd9,   0, 1,  8'd9, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0,  8'd8, 0, 0)); // dir flip, step down
        vecs.push_back(mk(0, 1, 8'd9,   1, 1,  8'd9, 1, 0)); // ld at top: no wrap

        // ---- async reset at time zero ----
        rst = 1'b0;
        drive(0, 0, 8'd0, 0, 1);
        #2;
        check("rst_count_s", 0, 32'(count_s), 32'd0);
        check("rst_wrap_s",  0, 32'(wrap_s),  32'd0);
        check("rst_tc_s",    0, 32'(tc_s),    32'd0);
        check("rst_count_f", 0, 32'(count_f), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- table-driven vectors ----
        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].ldv, vecs[i].en, vecs[i].dir);
            @(posedge clk);
            #1;
            check("vec_count", i, 32'(count_s), 32'(vecs[i].exp_count));
            check("vec_tc",    i, 32'(tc_s),    32'(vecs[i].exp_tc));
            check("vec_wrap",  i, 32'(wrap_s),  32'(vecs[i].exp_wrap));
        end

        // ---- async reset in mid-count, coincident with ld/en ----
        drive(0, 1, 8'h5A, 0, 1);
        @(posedge clk);
        #1;
        check("ld5a_count_s", 0, 32'(count_s), 32'd9);
        check("ld5a_count_f", 0, 32'(count_f), 32'h5A);
        #2;
        rst = 1'b0;
        drive(0, 1, 8'h33, 1, 1);
        #1;
        check("async_count_f", 0, 32'(count_f), 32'd0);
        check("async_count_s", 0, 32'(count_s), 32'd0);
        check("async_wrap_f",  0, 32'(wrap_f),  32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_f", 0, 32'(count_f), 32'd0);
        check("rst_hold_s", 0, 32'(count_s), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'd0, 0, 1);
        @(posedge clk);
        #1;
        check("rel_count_f", 0, 32'(count_f), 32'd0);

        // ---- full-range top boundary ----
        drive(0, 1, 8'hFF, 0, 1);
        @(posedge clk);
        #1;
        check("full_top_count", 0, 32'(count_f), 32'd255);
        check("full_top_tc",    0, 32'(tc_f),    32'd1);
        drive(0, 0, 8'd0, 1, 1);
        @(posedge clk);
        #1;
`ifdef PUDC_SATURATE_EN
        check("full_step_count", 0, 32'(count_f), 32'd255);
`else
        check("full_step_count", 0, 32'(count_f), 32'd0);
`endif
        check("full_step_wrap", 0, 32'(wrap_f), 32'd1);
        drive(0, 0, 8'd0, 0, 1);
        @(posedge clk);
        #1;
        check("full_pulse_end", 0, 32'(wrap_f), 32'd0);
        check("small_pulse_end", 0, 32'(wrap_s), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
